// File: rtl/ccff_chain_loader_pkg.sv
// ccff_chain_loader_pkg: shared state and mode types for the configuration-chain loader.
package ccff_chain_loader_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
   typedef enum logic {LOAD, VERIFY} mode_t;
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: holds one host word and presents it MSB-first, one bit per shift.
module ccff_word_serializer #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   output logic              msb,
   output logic              last_bit
);
   localparam int WC_W = $clog2(WORD_W + 1);
   logic [WORD_W-1:0] sr_q, sr_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   always_comb begin
      sr_d   = load ? data : shift ? sr_q << 1 : sr_q;
      wcnt_d = load ? WC_W'(WORD_W) : shift ? wcnt_q - 1'b1 : wcnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q   <= '0;
         wcnt_q <= '0;
      end else begin
         sr_q   <= sr_d;
         wcnt_q <= wcnt_d;
      end
   end
   assign msb      = sr_q[WORD_W-1];
   assign last_bit = wcnt_q == WC_W'(1);
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes host words into a ccff chain head, gating the chain clock,
// with an optional verify pass comparing the chain tail against the resent stream.
module ccff_chain_loader
   import ccff_chain_loader_pkg::*;
#(
   parameter  int WORD_W    = 8,
   parameter  int CHAIN_LEN = 24,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   output logic              chain_clk_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              verify_err
);
   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             err_q, err_d;
   logic             msb, last_bit, load, shift;
   assign load  = state_q == FETCH && s_valid;
   assign shift = state_q == SHIFT;
   ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk     (prog_clk),
      .rst     (pReset),
      .load    (load),
      .shift   (shift),
      .data    (s_data),
      .msb     (msb),
      .last_bit(last_bit)
   );
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      bit_cnt_d = bit_cnt_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (start) begin
               state_d = FETCH;
               mode_d  = mode_t'(verify);
               err_d   = 1'b0;
            end
         end
         FETCH: state_d = s_valid ? SHIFT : FETCH;
         SHIFT: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // tail holds the bit stored by the previous pass at this same position
            if (mode_q == VERIFY && ccff_tail != msb) err_d = 1'b1;
            state_d = bit_cnt_q == CNT_W'(CHAIN_LEN - 1) ? DONE : last_bit ? FETCH : SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q   <= IDLE;
         mode_q    <= LOAD;
         bit_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         bit_cnt_q <= bit_cnt_d;
         err_q     <= err_d;
      end
   end
   assign s_ready      = state_q == FETCH;
   assign chain_clk_en = shift;
   assign ccff_head    = shift & msb;
   assign busy         = state_q != IDLE;
   assign done         = state_q == DONE;
   assign verify_err   = err_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: drives 24- and 20-bit chain loaders against behavioural chains,
// with expected pass results queued at start and compared on each done pulse.
module tb_ccff_chain_loader;
   logic       prog_clk = 0, pReset = 1, start24 = 0, start20 = 0, verify = 0, s_valid = 0;
   logic [7:0] s_data = 0;
   logic       s_ready24, head24, en24, busy24, done24, err24;
   logic       s_ready20, head20, en20, busy20, done20, err20;
   logic [23:0] ch24 = 0;
   logic [19:0] ch20 = 0;
   typedef struct {logic [23:0] chain; logic err; int ens;} exp_t;
   exp_t q24[$], q20[$];
   int checks = 0, failures = 0;
   int ens24 = 0, dones24 = 0, ens20 = 0, dones20 = 0;
   logic prev_en24 = 0, prev_en20 = 0;

   always #5 prog_clk = ~prog_clk;

   ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(24)) u_dut24 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start24), .verify(verify),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready24), .ccff_head(head24),
      .chain_clk_en(en24), .ccff_tail(ch24[23]), .busy(busy24), .done(done24),
      .verify_err(err24));
   ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) u_dut20 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start20), .verify(verify),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready20), .ccff_head(head20),
      .chain_clk_en(en20), .ccff_tail(ch20[19]), .busy(busy20), .done(done20),
      .verify_err(err20));

   always @(posedge prog_clk) begin
      if (en24) ch24 <= {ch24[22:0], head24};
      if (en20) ch20 <= {ch20[18:0], head20};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge prog_clk) begin
      exp_t e;
      if (en24) ens24++;
      if (en20) ens20++;
      if (done24) begin
         dones24++;
         chk("done24_after_shift", prev_en24, 1);
         if (q24.size() > 0) begin
            e = q24.pop_front();
            chk("chain24", ch24, e.chain);
            chk("err24", err24, e.err);
            chk("ens24", ens24, e.ens);
         end else chk("sb24_underflow", q24.size(), 1);
      end
      if (done20) begin
         dones20++;
         chk("done20_after_shift", prev_en20, 1);
         if (q20.size() > 0) begin
            e = q20.pop_front();
            chk("chain20", ch20, e.chain);
            chk("err20", err20, e.err);
            chk("ens20", ens20, e.ens);
         end else chk("sb20_underflow", q20.size(), 1);
      end
      prev_en24 = en24;
      prev_en20 = en20;
   end

   task automatic wait_ready(input logic sel);
      int n = 0;
      while (!(sel ? s_ready20 : s_ready24) && n < 100) begin
         @(negedge prog_clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", n, 0);
   endtask

   task automatic send_word(input logic sel, input logic [7:0] w);
      @(negedge prog_clk);
      s_data  = w;
      s_valid = 1;
      wait_ready(sel);
      @(posedge prog_clk);
      #1 s_valid = 0;
   endtask

   task automatic pulse_start(input logic sel, input logic vf);
      @(negedge prog_clk);
      verify = vf;
      if (sel) start20 = 1; else start24 = 1;
      @(posedge prog_clk);
      #1 start24 = 0;
      start20 = 0;
   endtask

   task automatic wait_idle24();
      int n = 0;
      while (busy24 && n < 300) begin
         @(negedge prog_clk);
         n++;
      end
      if (n >= 300) chk("idle24_timeout", n, 0);
      repeat (3) @(negedge prog_clk);
   endtask

   task automatic run24(input logic vf, input logic [7:0] w0, w1, w2, input int gap,
                        input logic mid_start);
      exp_t e;
      logic [23:0] stream;
      int gap_en;
      stream  = {w0, w1, w2};
      e.chain = stream;
      e.err   = vf && (stream != ch24);
      e.ens   = 24;
      q24.push_back(e);
      pulse_start(0, vf);
      ens24   = 0;
      dones24 = 0;
      @(negedge prog_clk);
      chk("err_cleared_on_start", err24, 0);
      chk("busy_after_start", busy24, 1);
      send_word(0, w0);
      if (mid_start) pulse_start(0, ~vf);
      if (gap > 0) begin
         @(negedge prog_clk);
         wait_ready(0);
         gap_en = 0;
         repeat (gap) begin
            @(negedge prog_clk);
            gap_en += int'(en24);
         end
         chk("gap_no_enable", gap_en, 0);
      end
      send_word(0, w1);
      send_word(0, w2);
      wait_idle24();
      chk("single_done24", dones24, 1);
      chk("err_holds", err24, e.err);
   endtask

   initial begin
      exp_t e;
      int n, rdy_after;
      #2;
      chk("rst_s_ready", s_ready24, 0);
      chk("rst_head", head24, 0);
      chk("rst_en", en24, 0);
      chk("rst_busy", busy24, 0);
      chk("rst_done", done24, 0);
      chk("rst_err", err24, 0);
      @(negedge prog_clk);
      pReset = 0;
      // tests 1 and 2: load, matching verify, mismatching verify
      run24(0, 8'hA5, 8'h3C, 8'hF0, 0, 0);
      run24(1, 8'hA5, 8'h3C, 8'hF0, 0, 0);
      run24(1, 8'hA5, 8'h3C, 8'hF1, 0, 0);
      // test 3: host stalls between words
      run24(0, 8'h12, 8'h34, 8'h56, 10, 0);
      // test 6: start while busy
      run24(0, 8'hC3, 8'h99, 8'h0F, 0, 1);
      // test 5: reset during third bit of word 2
      pulse_start(0, 0);
      ens24 = 0;
      send_word(0, 8'hFF);
      send_word(0, 8'h00);
      n = 0;
      while (ens24 != 11 && n < 100) begin
         @(negedge prog_clk);
         #1 n++;
      end
      chk("midpass_reached", ens24, 11);
      pReset = 1;
      #1;
      chk("mid_rst_s_ready", s_ready24, 0);
      chk("mid_rst_head", head24, 0);
      chk("mid_rst_en", en24, 0);
      chk("mid_rst_busy", busy24, 0);
      chk("mid_rst_done", done24, 0);
      chk("mid_rst_err", err24, 0);
      @(negedge prog_clk);
      pReset = 0;
      run24(0, 8'h5A, 8'hC3, 8'h0F, 0, 0);
      // test 4: 20-bit chain with a partial final word
      e.chain = 24'h0A53CF;
      e.err   = 0;
      e.ens   = 20;
      q20.push_back(e);
      pulse_start(1, 0);
      ens20   = 0;
      dones20 = 0;
      send_word(1, 8'hA5);
      send_word(1, 8'h3C);
      send_word(1, 8'hF0);
      rdy_after = 0;
      repeat (30) begin
         @(negedge prog_clk);
         rdy_after += int'(s_ready20);
      end
      chk("no_fetch_beyond_chain", rdy_after, 0);
      chk("single_done20", dones20, 1);
      chk("sb_drained", q24.size() + q20.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
